// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains an 8-bit FIFO read port and packs BYTES consecutive
// bytes into one wide word on a valid/ready output. A flush pulse emits the
// bytes collected so far as a partial word with a lane-keep mask.
module fifo_word_packer #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [DATA_W-1:0]       fifo_data,
    output logic                    RDEN,
    input  logic                    flush,
    output logic [DATA_W*BYTES-1:0] word_out,
    output logic [BYTES-1:0]        word_keep,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy
);

    localparam int CW = $clog2(BYTES + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(BYTES);

    typedef logic [BYTES-1:0][DATA_W-1:0] pack_t;

    // Collection state: reads issued, bytes landed, read in flight, flush and
    // held-full-word flags, plus the lane buffer being filled.
    logic [CW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           lane_q, lane_d;
    logic                    pend_q, pend_d;
    logic                    flushing_q, flushing_d;
    logic                    full_q, full_d;
    pack_t                   packBuf_q, packBuf_d;

    // Output register stage.
    logic [DATA_W*BYTES-1:0] wordOut_q, wordOut_d;
    logic [BYTES-1:0]        wordKeep_q, wordKeep_d;
    logic                    wordValid_q, wordValid_d;

    logic                    rdEn;
    logic                    outFree;
    logic                    complete;
    logic [BYTES-1:0]        partialKeep;

    // Next-state logic. The lane buffer only ever holds bytes captured for
    // the current word; it is cleared whenever a word leaves, so lanes past
    // the capture point are already zero when a partial word is emitted.
    always_comb begin
        issued_d    = issued_q;
        lane_d      = lane_q;
        pend_d      = 1'b0;
        flushing_d  = flushing_q;
        full_d      = full_q;
        packBuf_d   = packBuf_q;
        wordOut_d   = wordOut_q;
        wordKeep_d  = wordKeep_q;
        wordValid_d = wordValid_q;
        complete    = 1'b0;
        partialKeep = '0;

        outFree = !wordValid_q || word_ready;
        rdEn    = !rst && !fifo_empty && (issued_q < FULL_COUNT)
                  && !flushing_q && !flush && !full_q;

        if (rdEn) begin
            issued_d = issued_q + CW'(1);
            pend_d   = 1'b1;
        end

        if (pend_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_q == CW'(i)) begin
                    packBuf_d[i] = fifo_data;
                end
            end
            lane_d = lane_q + CW'(1);
        end

        if (wordValid_q && word_ready) begin
            wordValid_d = 1'b0;
        end

        for (int i = 0; i < BYTES; i++) begin
            partialKeep[i] = (CW'(i) < lane_q);
        end

        complete = (lane_d == FULL_COUNT);

        if (complete) begin
            if (outFree) begin
                wordOut_d   = packBuf_d;
                wordKeep_d  = '1;
                wordValid_d = 1'b1;
                issued_d    = '0;
                lane_d      = '0;
                full_d      = 1'b0;
                flushing_d  = 1'b0;
                packBuf_d   = '0;
            end else begin
                full_d = 1'b1;
            end
        end else if (flushing_q && !pend_q) begin
            if (lane_q == '0) begin
                flushing_d = 1'b0;
                issued_d   = '0;
            end else if (outFree) begin
                wordOut_d   = packBuf_q;
                wordKeep_d  = partialKeep;
                wordValid_d = 1'b1;
                issued_d    = '0;
                lane_d      = '0;
                flushing_d  = 1'b0;
                packBuf_d   = '0;
            end
        end

        // A flush landing on the last byte's capture, on a held full word or
        // on an active flush adds nothing: the normal word path covers it.
        if (flush && !flushing_q && !full_q && !complete) begin
            flushing_d = 1'b1;
        end
    end

    // State register with synchronous reset; reset drops everything collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q    <= '0;
            lane_q      <= '0;
            pend_q      <= 1'b0;
            flushing_q  <= 1'b0;
            full_q      <= 1'b0;
            packBuf_q   <= '0;
            wordOut_q   <= '0;
            wordKeep_q  <= '0;
            wordValid_q <= 1'b0;
        end else begin
            issued_q    <= issued_d;
            lane_q      <= lane_d;
            pend_q      <= pend_d;
            flushing_q  <= flushing_d;
            full_q      <= full_d;
            packBuf_q   <= packBuf_d;
            wordOut_q   <= wordOut_d;
            wordKeep_q  <= wordKeep_d;
            wordValid_q <= wordValid_d;
        end
    end

    assign RDEN       = rdEn;
    assign word_out   = wordOut_q;
    assign word_keep  = wordKeep_q;
    assign word_valid = wordValid_q;
    assign busy       = pend_q || (lane_q != '0) || full_q || flushing_q || wordValid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: drives fifo_word_packer from a queue-based FIFO model.
// Expected words come from grouping the bytes actually pulled from the FIFO
// into fixed-size words (or a zero-padded partial word on flush).
module tb_fifo_word_packer;

    localparam int DATA_W = 8;
    localparam int BYTES  = 4;

    logic                    clk;
    logic                    rst;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_data;
    logic                    RDEN;
    logic                    flush;
    logic [DATA_W*BYTES-1:0] word_out;
    logic [BYTES-1:0]        word_keep;
    logic                    word_valid;
    logic                    word_ready;
    logic                    busy;

    logic [7:0]  fifoQ[$];
    logic [7:0]  pendingBytes[$];
    logic [31:0] expWordQ[$];
    logic [3:0]  expKeepQ[$];
    logic [31:0] acceptedQ[$];
    logic [3:0]  acceptedKeepQ[$];

    int   vectors;
    int   miscompares;
    int   rdenCount;
    logic rdSeen;
    logic validSeen;

    fifo_word_packer #(.DATA_W(DATA_W), .BYTES(BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .RDEN       (RDEN),
        .flush      (flush),
        .word_out   (word_out),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packs whatever bytes are collected into one expected word, low lane first.
    task automatic packWord();
        logic [31:0] w;
        logic [3:0]  k;
        w = '0;
        k = '0;
        for (int i = 0; i < pendingBytes.size(); i++) begin
            w[8*i +: 8] = pendingBytes[i];
            k[i]        = 1'b1;
        end
        if (pendingBytes.size() > 0) begin
            expWordQ.push_back(w);
            expKeepQ.push_back(k);
        end
        pendingBytes.delete();
    endtask

    // One clock: drive inputs at negedge, sample/score before posedge, then
    // let the FIFO model answer an accepted read just after the edge.
    task automatic applyStimulus(input logic fl, input logic rdy, input logic fe);
        logic [7:0] b;
        @(negedge clk);
        flush      = fl;
        word_ready = rdy;
        fifo_empty = fe || (fifoQ.size() == 0);
        #1;
        rdSeen    = RDEN;
        validSeen = word_valid;
        if (RDEN) rdenCount++;
        if (word_valid) begin
            checkOutput("word_expected", 64'(expWordQ.size() > 0), 64'd1);
            if (expWordQ.size() > 0) begin
                checkOutput("word_out", 64'(word_out), 64'(expWordQ[0]));
                checkOutput("word_keep", 64'(word_keep), 64'(expKeepQ[0]));
            end
            if (word_ready) begin
                acceptedQ.push_back(word_out);
                acceptedKeepQ.push_back(word_keep);
                if (expWordQ.size() > 0) begin
                    void'(expWordQ.pop_front());
                    void'(expKeepQ.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (rdSeen) begin
            checkOutput("read_while_empty", 64'(fifoQ.size() > 0), 64'd1);
            if (fifoQ.size() > 0) begin
                b         = fifoQ.pop_front();
                fifo_data = b;
                pendingBytes.push_back(b);
                if (pendingBytes.size() == BYTES) packWord();
            end
        end
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        pendingBytes.delete();
        expWordQ.delete();
        expKeepQ.delete();
        checkOutput("reset_RDEN", 64'(RDEN), 64'd0);
        checkOutput("reset_valid", 64'(word_valid), 64'd0);
        checkOutput("reset_word_out", 64'(word_out), 64'd0);
        checkOutput("reset_keep", 64'(word_keep), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        int fourthRead;
        int firstValid;
        int reads;
        int startCount;
        logic rr;

        vectors     = 0;
        miscompares = 0;
        rdenCount   = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        word_ready  = 1'b0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;

        // Streaming with output always ready; FIFO already holds 1..8 while
        // reset is asserted, so RDEN must stay low through reset.
        $display("[TB] streaming 1..8");
        for (int i = 1; i <= 8; i++) fifoQ.push_back(8'(i));
        applyReset(3);
        acceptedQ.delete();
        acceptedKeepQ.delete();
        fourthRead = -1;
        firstValid = -1;
        reads      = 0;
        startCount = rdenCount;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (rdSeen) begin
                reads++;
                if (reads == 4) fourthRead = k;
            end
            if (validSeen && firstValid < 0) firstValid = k;
        end
        // Read accepted at one edge, byte lands and word loads at the next,
        // so the valid word is first seen two samples after the 4th RDEN.
        checkOutput("t1_valid_latency", 64'(firstValid - fourthRead), 64'd2);
        checkOutput("t1_rden_count", 64'(rdenCount - startCount), 64'd8);
        checkOutput("t1_word_count", 64'(acceptedQ.size()), 64'd2);
        if (acceptedQ.size() == 2) begin
            checkOutput("t1_word0", 64'(acceptedQ[0]), 64'h04030201);
            checkOutput("t1_word1", 64'(acceptedQ[1]), 64'h08070605);
            checkOutput("t1_keep0", 64'(acceptedKeepQ[0]), 64'hF);
        end
        checkOutput("t1_busy_idle", 64'(busy), 64'd0);

        // Back-pressure: two words absorbed, then reads must stop.
        $display("[TB] back-pressure 1..12");
        acceptedQ.delete();
        acceptedKeepQ.delete();
        for (int i = 1; i <= 12; i++) fifoQ.push_back(8'(i));
        startCount = rdenCount;
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t2_rden_held", 64'(rdenCount - startCount), 64'd8);
        checkOutput("t2_valid_held", 64'(word_valid), 64'd1);
        checkOutput("t2_word_held", 64'(word_out), 64'h04030201);
        checkOutput("t2_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_word_count", 64'(acceptedQ.size()), 64'd3);
        if (acceptedQ.size() == 3) begin
            checkOutput("t2_word0", 64'(acceptedQ[0]), 64'h04030201);
            checkOutput("t2_word1", 64'(acceptedQ[1]), 64'h08070605);
            checkOutput("t2_word2", 64'(acceptedQ[2]), 64'h0C0B0A09);
        end

        // Partial word via flush.
        $display("[TB] flush partial");
        acceptedQ.delete();
        acceptedKeepQ.delete();
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        packWord();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_word_count", 64'(acceptedQ.size()), 64'd1);
        if (acceptedQ.size() == 1) begin
            checkOutput("t3_word", 64'(acceptedQ[0]), 64'h00002211);
            checkOutput("t3_keep", 64'(acceptedKeepQ[0]), 64'h3);
        end
        checkOutput("t3_busy_idle", 64'(busy), 64'd0);

        // Flush with nothing collected: no word, busy clears quickly.
        $display("[TB] empty flush");
        acceptedQ.delete();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_busy_clear", 64'(busy), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_no_word", 64'(acceptedQ.size()), 64'd0);

        // FIFO empty flag toggling every other cycle.
        $display("[TB] toggling empty 5..8");
        acceptedQ.delete();
        for (int i = 5; i <= 8; i++) fifoQ.push_back(8'(i));
        startCount = rdenCount;
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, (k % 2) == 0);
        checkOutput("t5_rden_count", 64'(rdenCount - startCount), 64'd4);
        checkOutput("t5_word_count", 64'(acceptedQ.size()), 64'd1);
        if (acceptedQ.size() == 1) checkOutput("t5_word", 64'(acceptedQ[0]), 64'h08070605);

        // Reset mid-word discards the two collected bytes.
        $display("[TB] reset mid-word");
        acceptedQ.delete();
        fifoQ.push_back(8'h55);
        fifoQ.push_back(8'h66);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6_busy_before", 64'(busy), 64'd1);
        applyReset(2);
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'hA0 + 8'(i));
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6_word_count", 64'(acceptedQ.size()), 64'd1);
        if (acceptedQ.size() == 1) checkOutput("t6_word", 64'(acceptedQ[0]), 64'hA3A2A1A0);

        // Randomized rounds: random bytes, ready and empty gaps, optional flush.
        $display("[TB] random rounds");
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) fifoQ.push_back(8'($urandom_range(0, 255)));
            for (int g = 0; g < 400 && fifoQ.size() > 0; g++) begin
                applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            end
            checkOutput("rand_fifo_drained", 64'(fifoQ.size()), 64'd0);
            for (int k = 0; k < 3; k++) applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b0);
            rr = ($urandom_range(0, 1) == 1);
            if (pendingBytes.size() > 0) begin
                packWord();
                applyStimulus(1'b1, rr, 1'b0);
            end else begin
                applyStimulus(rr, rr, 1'b0);
            end
            for (int g = 0; g < 200 && expWordQ.size() > 0; g++) begin
                applyStimulus(1'b0, $urandom_range(0, 2) != 0, 1'b0);
            end
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("rand_words_drained", 64'(expWordQ.size()), 64'd0);
            checkOutput("rand_busy_idle", 64'(busy), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
